// File: rtl/fxp_matmul_seq_pkg.sv
// Shared fixed-point helpers for the matrix engine: widths, saturation limits,
// FSM encoding and packed-element indexing.
package fxp_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Sum of P full 2N-bit products plus headroom for the addend.
  function automatic int acc_w(input int n, input int p);
    return 2 * n + clog2(p) + 1;
  endfunction

  function automatic logic [63:0] sat_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic int elem_off(input int i, input int j, input int p, input int n);
    return (i * p + j) * n;
  endfunction

endpackage

// File: rtl/fxp_matmul_seq_if.sv
// Request/result bundle for fxp_matmul_seq; master issues operands, slave computes.
interface fxp_matmul_seq_if #(
  parameter int N = 32,
  parameter int P = 4
);
  logic             start;
  logic             acc_en;
  logic [P*P*N-1:0] a;
  logic [P*P*N-1:0] b;
  logic [P*P*N-1:0] d;
  logic             ready;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [P*P*N-1:0] c;

  modport master (output start, acc_en, a, b, d,
                  input  ready, busy, done, overflow, c);
  modport slave  (input  start, acc_en, a, b, d,
                  output ready, busy, done, overflow, c);
endinterface

// File: rtl/fxp_matmul_seq_dot_sat.sv
// Combinational full-precision dot product, floor shift by Q, optional addend,
// then saturation to N bits.
module fxp_dot_sat
  import fxp_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 18,
  parameter int P = 4
) (
  input  logic [P-1:0][N-1:0] row_v,
  input  logic [P-1:0][N-1:0] col_v,
  input  logic [N-1:0]        addend,
  input  logic                add_en,
  output logic [N-1:0]        res,
  output logic                sat
);
  localparam int AW = acc_w(N, P);
  localparam int PW = 2 * N;
  localparam logic [N-1:0] SMAX = N'(sat_max(N));
  localparam logic [N-1:0] SMIN = N'(sat_min(N));

  logic [P-1:0][PW-1:0] prod;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] shifted;
  logic signed [AW-1:0] sum;

  for (genvar k = 0; k < P; k++) begin : g_mul
    assign prod[k] = PW'($signed(row_v[k])) * PW'($signed(col_v[k]));
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < P; k++)
      acc = acc + {{(AW-PW){prod[k][PW-1]}}, prod[k]};
    // kept as its own statement so the shift stays arithmetic (floor toward -inf)
    shifted = acc >>> Q;
    sum     = shifted + (add_en ? {{(AW-N){addend[N-1]}}, addend} : '0);
    sat     = ~((&sum[AW-1:N-1]) | ~(|sum[AW-1:N-1]));
    res     = sat ? (sum[AW-1] ? SMIN : SMAX) : sum[N-1:0];
  end

endmodule

// File: rtl/fxp_matmul_seq.sv
// Sequential PxP fixed-point matrix multiply-accumulate, one result element per clock,
// start/done handshake with sticky saturation flag.
module fxp_matmul_seq
  import fxp_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 18,
  parameter int P = 4
) (
  input logic               clk,
  input logic               reset,
  fxp_matmul_seq_if.slave   bus
);
  localparam int W  = P * P * N;
  localparam int IW = (clog2(P) < 1) ? 1 : clog2(P);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, d_q, d_d, c_q, c_d;
  logic            acc_en_q, acc_en_d;
  logic            ovf_q, ovf_d;
  logic            ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d;

  logic [P-1:0][N-1:0] row_v, col_v;
  logic [N-1:0]        addend, res;
  logic                sat;

  always_comb begin
    for (int k = 0; k < P; k++) begin
      row_v[k] = a_q[elem_off(int'(i_q), k, P, N) +: N];
      col_v[k] = b_q[elem_off(k, int'(j_q), P, N) +: N];
    end
    addend = d_q[elem_off(int'(i_q), int'(j_q), P, N) +: N];
  end

  fxp_dot_sat #(.N(N), .Q(Q), .P(P)) u_dot (
    .row_v  (row_v),
    .col_v  (col_v),
    .addend (addend),
    .add_en (acc_en_q),
    .res    (res),
    .sat    (sat)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    c_d      = c_q;
    acc_en_d = acc_en_q;
    ovf_d    = ovf_q;
    i_d      = i_q;
    j_d      = j_q;
    unique case (state_q)
      RUN: begin
        c_d[elem_off(int'(i_q), int'(j_q), P, N) +: N] = res;
        ovf_d = ovf_q | sat;
        if (j_q == IW'(P - 1)) begin
          j_d = '0;
          if (i_q == IW'(P - 1)) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      default: begin
        // IDLE and DONE both accept, giving back-to-back issue from DONE
        state_d = IDLE;
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          d_d      = bus.d;
          acc_en_d = bus.acc_en;
          ovf_d    = 1'b0;
          i_d      = '0;
          j_d      = '0;
          state_d  = RUN;
        end
      end
    endcase
    ready_d = (state_d != RUN);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      c_q      <= '0;
      acc_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      c_q      <= c_d;
      acc_en_q <= acc_en_d;
      ovf_q    <= ovf_d;
      i_q      <= i_d;
      j_q      <= j_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.c        = c_q;

endmodule
